// File: rtl/dot_product_accumulator_pkg.sv
// Shared types and widths for the dot-product accumulator and its multiplier.
// No logic; imported by the interface, the multiplier and the top.
package dot_product_accumulator_pkg;

   localparam int OP_W   = 4;
   localparam int PROD_W = 2 * OP_W;

   typedef enum logic [1:0] {
      ACCUM = 2'd0,
      DRAIN = 2'd1,
      DONE  = 2'd2
   } state_t;

   typedef struct packed {
      logic [OP_W-1:0] a;
      logic [OP_W-1:0] b;
   } op_pair_t;

endpackage

// File: rtl/dot_product_accumulator_if.sv
// Operand-pair input and result output handshakes of the dot-product accumulator.
// master = producer/consumer side, slave = the accumulator itself.
interface dot_product_accumulator_if #(
   parameter int ACC_W = 10
);

   logic                                      in_valid;
   logic                                      in_ready;
   logic [dot_product_accumulator_pkg::OP_W-1:0] in_a;
   logic [dot_product_accumulator_pkg::OP_W-1:0] in_b;
   logic                                      out_valid;
   logic                                      out_ready;
   logic [ACC_W-1:0]                          out_sum;
   logic                                      out_overflow;

   modport master (
      output in_valid, in_a, in_b, out_ready,
      input  in_ready, out_valid, out_sum, out_overflow
   );

   modport slave (
      input  in_valid, in_a, in_b, out_ready,
      output in_ready, out_valid, out_sum, out_overflow
   );

endinterface

// File: rtl/unsigned_array_multiplier.sv
// Combinational OP_W x OP_W unsigned array multiplier: zero latency, no handshake.
// Each row adds one gated partial product to the upper bits of the previous row.
module unsigned_array_multiplier
   import dot_product_accumulator_pkg::*;
(
   input  logic [OP_W-1:0]   a,
   input  logic [OP_W-1:0]   b,
   output logic [PROD_W-1:0] product
);

   always_comb begin
      logic [OP_W:0] row;
      product    = '0;
      row        = {1'b0, a & {OP_W{b[0]}}};
      product[0] = row[0];
      for (int i = 1; i < OP_W; i++) begin
         row        = {1'b0, a & {OP_W{b[i]}}} + {1'b0, row[OP_W:1]};
         product[i] = row[0];
      end
      product[PROD_W-1:OP_W] = row[OP_W:1];
   end

endmodule

// File: rtl/dot_product_accumulator.sv
// Accumulates N_TERMS registered 4x4 products; result valid 2 cycles after the last accept.
// Input stalls (in_ready=0) from the last accept until the result is taken; result holds while out_ready=0.
module dot_product_accumulator
   import dot_product_accumulator_pkg::*;
#(
   parameter int N_TERMS = 4,
   parameter int ACC_W   = 10
) (
   input  logic                      clk,
   input  logic                      rst_n,
   dot_product_accumulator_if.slave  bus
);

   localparam int                 CNT_W = $clog2(N_TERMS) + 1;
   localparam int                 SUM_W = ACC_W + 1;
   localparam logic [CNT_W-1:0]   LAST  = CNT_W'(N_TERMS - 1);

   state_t            state;
   state_t            state_nxt;
   logic [CNT_W-1:0]  cnt;
   op_pair_t          op;
   logic              pend;
   logic [ACC_W-1:0]  acc;
   logic              ovf;
   logic [PROD_W-1:0] product;
   logic [SUM_W-1:0]  sum;
   logic              in_fire;
   logic              out_fire;

   assign in_fire  = bus.in_valid  & bus.in_ready;
   assign out_fire = bus.out_valid & bus.out_ready;

   unsigned_array_multiplier u_mult (
      .a       (op.a),
      .b       (op.b),
      .product (product)
   );

   // Extra top bit captures the carry out of the accumulator width.
   assign sum = {1'b0, acc} + SUM_W'(product);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ACCUM;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         ACCUM:   if (in_fire && cnt == LAST) state_nxt = DRAIN;
         DRAIN:   state_nxt = DONE;
         DONE:    if (bus.out_ready) state_nxt = ACCUM;
         default: state_nxt = ACCUM;
      endcase
   end

   always_comb begin
      bus.in_ready     = 1'b0;
      bus.out_valid    = 1'b0;
      bus.out_sum      = '0;
      bus.out_overflow = 1'b0;
      unique case (state)
         ACCUM: bus.in_ready = 1'b1;
         DRAIN: ;
         DONE: begin
            bus.out_valid    = 1'b1;
            bus.out_sum      = acc;
            bus.out_overflow = ovf;
         end
         default: ;
      endcase
   end

   // pend marks that op holds a product not yet folded into acc.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt  <= '0;
         op   <= '0;
         pend <= 1'b0;
         acc  <= '0;
         ovf  <= 1'b0;
      end else if (out_fire) begin
         cnt  <= '0;
         pend <= 1'b0;
         acc  <= '0;
         ovf  <= 1'b0;
      end else begin
         if (in_fire) begin
            op  <= '{a: bus.in_a, b: bus.in_b};
            cnt <= cnt + CNT_W'(1);
         end
         pend <= in_fire;
         if (pend) begin
            acc <= sum[ACC_W-1:0];
            ovf <= ovf | sum[ACC_W];
         end
      end
   end

endmodule

// File: tb/tb_dot_product_accumulator.sv
// Bench for dot_product_accumulator: directed frames plus a random stress run on ACC_W=10 and ACC_W=9 instances.
module tb_dot_product_accumulator;

   typedef struct packed {
      logic [15:0] sum;
      logic        ovf;
   } exp_t;

   logic       clk      = 1'b0;
   logic       rst_n    = 1'b0;
   logic       in_valid = 1'b0;
   logic [3:0] in_a     = '0;
   logic [3:0] in_b     = '0;
   logic       out_ready = 1'b0;
   logic       man_rdy  = 1'b0;
   logic       rand_rdy = 1'b0;
   logic       sel      = 1'b0;
   logic       cur_in_ready;

   int n_vec = 0;
   int n_err = 0;

   exp_t        q0[$];
   exp_t        q1[$];
   logic        prev_hold [2];
   logic [15:0] prev_sum  [2];
   logic        prev_ovf  [2];

   dot_product_accumulator_if #(.ACC_W(10)) if10 ();
   dot_product_accumulator_if #(.ACC_W(9))  if9  ();

   assign if10.in_valid  = in_valid & ~sel;
   assign if10.in_a      = in_a;
   assign if10.in_b      = in_b;
   assign if10.out_ready = out_ready & ~sel;
   assign if9.in_valid   = in_valid & sel;
   assign if9.in_a       = in_a;
   assign if9.in_b       = in_b;
   assign if9.out_ready  = out_ready & sel;
   assign cur_in_ready   = sel ? if9.in_ready : if10.in_ready;

   dot_product_accumulator #(.N_TERMS(4), .ACC_W(10)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if10.slave)
   );

   dot_product_accumulator #(.N_TERMS(4), .ACC_W(9)) dut9 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if9.slave)
   );

   always #5 clk = ~clk;

   initial begin
      forever begin
         @(posedge clk);
         #2;
         out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : man_rdy;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got time limit, required self-termination");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int qsz();
      return sel ? q1.size() : q0.size();
   endfunction

   task automatic mon_step(input int idx, input logic vld, input logic rdy,
                           input logic [15:0] sum, input logic ovf, input logic irdy);
      exp_t e;
      int   sz;
      if (prev_hold[idx]) begin
         check("hold_valid", 32'(vld), 1);
         check("hold_sum", 32'(sum), 32'(prev_sum[idx]));
         check("hold_ovf", 32'(ovf), 32'(prev_ovf[idx]));
      end
      if (vld) check("in_ready_while_out_valid", 32'(irdy), 0);
      if (vld && rdy) begin
         sz = (idx == 0) ? q0.size() : q1.size();
         check("result_expected", 32'(sz != 0), 1);
         if (sz != 0) begin
            if (idx == 0) e = q0.pop_front();
            else          e = q1.pop_front();
            check("out_sum", 32'(sum), 32'(e.sum));
            check("out_overflow", 32'(ovf), 32'(e.ovf));
         end
      end
      prev_hold[idx] = vld && !rdy;
      prev_sum[idx]  = sum;
      prev_ovf[idx]  = ovf;
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_hold[0] = 1'b0;
         prev_hold[1] = 1'b0;
      end else begin
         mon_step(0, if10.out_valid, if10.out_ready, 16'(if10.out_sum), if10.out_overflow, if10.in_ready);
         mon_step(1, if9.out_valid, if9.out_ready, 16'(if9.out_sum), if9.out_overflow, if9.in_ready);
      end
   end

   // Called at posedge+1; returns at posedge+1 just after the accepting edge.
   task automatic send_pair(input logic [3:0] a, input logic [3:0] b);
      logic r;
      logic done;
      done     = 1'b0;
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      for (int k = 0; k < 200 && !done; k++) begin
         @(negedge clk);
         r = cur_in_ready;
         @(posedge clk);
         #1;
         if (r) done = 1'b1;
      end
      in_valid = 1'b0;
      if (!done) check("accept_timeout", 32'(done), 1);
   endtask

   // gap_mode: 0 = back-to-back, 1 = fixed 1..3 idle cycles, 2 = random 0..2 idle cycles.
   task automatic send_frame(input logic [15:0] av, input logic [15:0] bv, input int gap_mode,
                             input logic [15:0] es, input logic eo);
      exp_t e;
      int   g;
      e = '{sum: es, ovf: eo};
      if (sel) q1.push_back(e);
      else     q0.push_back(e);
      for (int i = 0; i < 4; i++) begin
         if (i > 0) begin
            g = (gap_mode == 1) ? 1 + (i % 3) : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
            for (int j = 0; j < g; j++) begin
               @(negedge clk);
               check("gap_in_ready", 32'(cur_in_ready), 1);
               @(posedge clk);
               #1;
            end
         end
         send_pair(av[4*i +: 4], bv[4*i +: 4]);
      end
   endtask

   task automatic wait_drain();
      int k;
      k = 0;
      while (qsz() != 0 && k < 400) begin
         @(posedge clk);
         #1;
         k++;
      end
      if (qsz() != 0) check("drain_timeout", 32'(qsz()), 0);
   endtask

   initial begin
      logic [15:0] av;
      logic [15:0] bv;
      int          k;
      // pairs (3,5),(15,15),(0,9),(7,2): 15+225+0+14 = 254
      av = {4'd7, 4'd0, 4'd15, 4'd3};
      bv = {4'd2, 4'd9, 4'd15, 4'd5};

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", 32'(if10.in_ready), 1);
      check("rst_out_valid", 32'(if10.out_valid), 0);
      check("rst_out_sum", 32'(if10.out_sum), 0);
      check("rst_out_overflow", 32'(if10.out_overflow), 0);
      check("rst9_in_ready", 32'(if9.in_ready), 1);
      check("rst9_out_valid", 32'(if9.out_valid), 0);
      @(posedge clk);
      #1;
      rst_n   = 1'b1;
      man_rdy = 1'b1;
      @(posedge clk);
      #1;

      // Back-to-back pairs, check result timing
      sel = 1'b0;
      send_frame(av, bv, 0, 16'd254, 1'b0);
      @(negedge clk);
      check("lat_drain_out_valid", 32'(if10.out_valid), 0);
      check("lat_drain_in_ready", 32'(if10.in_ready), 0);
      @(negedge clk);
      check("lat_done_out_valid", 32'(if10.out_valid), 1);
      @(negedge clk);
      check("lat_after_out_valid", 32'(if10.out_valid), 0);
      check("lat_after_in_ready", 32'(if10.in_ready), 1);
      @(posedge clk);
      #1;
      wait_drain();

      // Gapped input
      send_frame(av, bv, 1, 16'd254, 1'b0);
      wait_drain();

      // Output stall with ignored input pulses
      man_rdy = 1'b0;
      send_frame(av, bv, 0, 16'd254, 1'b0);
      k = 0;
      while (!if10.out_valid && k < 20) begin
         @(posedge clk);
         #1;
         k++;
      end
      check("stall_reached_done", 32'(if10.out_valid), 1);
      for (int i = 0; i < 10; i++) begin
         in_valid = (i % 2 == 0);
         in_a     = 4'd9;
         in_b     = 4'd9;
         @(negedge clk);
         check("stall_in_ready", 32'(if10.in_ready), 0);
         check("stall_out_sum", 32'(if10.out_sum), 254);
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      man_rdy  = 1'b1;
      wait_drain();
      send_frame(16'h1111, 16'h1111, 0, 16'd4, 1'b0);
      wait_drain();

      // ACC_W=9: 900 mod 512 = 388 with overflow, then a clean frame
      sel = 1'b1;
      send_frame(16'hFFFF, 16'hFFFF, 0, 16'd388, 1'b1);
      wait_drain();
      send_frame(16'h2222, 16'h2222, 0, 16'd16, 1'b0);
      wait_drain();

      // Reset after two accepted pairs
      sel = 1'b0;
      send_pair(4'd7, 4'd7);
      send_pair(4'd7, 4'd7);
      rst_n = 1'b0;
      #1;
      check("midrst_in_ready", 32'(if10.in_ready), 1);
      check("midrst_out_valid", 32'(if10.out_valid), 0);
      check("midrst_out_sum", 32'(if10.out_sum), 0);
      check("midrst_out_overflow", 32'(if10.out_overflow), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      // (1,2),(2,3),(3,4),(4,5): 2+6+12+20 = 40
      send_frame(16'h4321, 16'h5432, 0, 16'd40, 1'b0);
      wait_drain();

      // Random stress on both widths
      rand_rdy = 1'b1;
      for (int f = 0; f < 1000; f++) begin
         int   w;
         int   acc;
         int   s;
         int   a;
         int   b;
         logic o;
         sel = 1'($urandom_range(0, 1));
         w   = sel ? 9 : 10;
         acc = 0;
         o   = 1'b0;
         for (int i = 0; i < 4; i++) begin
            a = int'($urandom_range(0, 15));
            b = int'($urandom_range(0, 15));
            av[4*i +: 4] = 4'(a);
            bv[4*i +: 4] = 4'(b);
            s = acc + a * b;
            if (s >= (1 << w)) o = 1'b1;
            acc = s % (1 << w);
         end
         send_frame(av, bv, 2, 16'(acc), o);
         wait_drain();
      end
      rand_rdy = 1'b0;

      check("q0_empty", 32'(q0.size()), 0);
      check("q1_empty", 32'(q1.size()), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
